// File: rtl/execute.sv
// Execute stage of the RV32I pipeline: ALU, branch/jump resolution, data-memory
// address/store data, combinational redirect and the EX/MEM register.
module execute (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_vld,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_rs1_raddr,
  input  logic [4:0]  i_rs2_raddr,
  input  logic [31:0] i_rs1_rdata,
  input  logic [31:0] i_rs2_rdata,
  input  logic [31:0] i_imm,
  input  logic [3:0]  i_alu_op,
  input  logic        i_alu_src,
  input  logic [2:0]  i_opsel,
  input  logic        i_branch,
  input  logic        i_jal,
  input  logic        i_jalr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic        i_mem_reg,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_waddr,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_vld,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic [31:0] o_nxt_pc,
  output logic [4:0]  o_rs1_raddr,
  output logic [4:0]  o_rs2_raddr,
  output logic [31:0] o_rs1_rdata,
  output logic [31:0] o_rs2_rdata,
  output logic [2:0]  o_opsel,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic        o_mem_reg,
  output logic [31:0] o_res,
  output logic [4:0]  o_rd_waddr,
  output logic        o_rd_wen
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SHW   = 5;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASSB = 4'd10;
  localparam logic [3:0] OP_AUIPC = 4'd11;

  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] nxt_pc;
  logic [XLEN-1:0] res;
  logic            cond;
  logic            taken;

  // ALU
  always_comb begin
    alu_a   = i_rs1_rdata;
    alu_b   = i_alu_src ? i_imm : i_rs2_rdata;
    shamt   = alu_b[SHW-1:0];
    alu_res = '0;
    case (i_alu_op)
      OP_ADD:   alu_res = alu_a + alu_b;
      OP_SUB:   alu_res = alu_a - alu_b;
      OP_SLL:   alu_res = alu_a << shamt;
      OP_SLT:   alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
      OP_SLTU:  alu_res = {31'd0, alu_a < alu_b};
      OP_XOR:   alu_res = alu_a ^ alu_b;
      OP_SRL:   alu_res = alu_a >> shamt;
      OP_SRA:   alu_res = XLEN'($signed(alu_a) >>> shamt);
      OP_OR:    alu_res = alu_a | alu_b;
      OP_AND:   alu_res = alu_a & alu_b;
      OP_PASSB: alu_res = alu_b;
      OP_AUIPC: alu_res = i_pc + i_imm;
      default:  alu_res = '0;
    endcase
  end

  // Branch condition always compares the two register operands
  always_comb begin
    cond = 1'b0;
    case (i_opsel)
      3'b000:  cond = (i_rs1_rdata == i_rs2_rdata);
      3'b001:  cond = (i_rs1_rdata != i_rs2_rdata);
      3'b100:  cond = ($signed(i_rs1_rdata) <  $signed(i_rs2_rdata));
      3'b101:  cond = ($signed(i_rs1_rdata) >= $signed(i_rs2_rdata));
      3'b110:  cond = (i_rs1_rdata <  i_rs2_rdata);
      3'b111:  cond = (i_rs1_rdata >= i_rs2_rdata);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    taken    = i_jal | i_jalr | (i_branch & cond);
    pc_plus4 = i_pc + 32'd4;
    target   = i_jalr ? ((i_rs1_rdata + i_imm) & ~32'd1) : (i_pc + i_imm);
    nxt_pc   = taken ? target : pc_plus4;
    res      = (i_jal | i_jalr) ? pc_plus4 : alu_res;
  end

  // Redirect is held off while stalled so it fires exactly once on release
  assign o_redirect    = i_vld & taken & ~i_stall & ~i_rst;
  assign o_redirect_pc = target;

  // EX/MEM register: reset and flush both clear, stall holds
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_vld        <= 1'b0;
      o_inst       <= '0;
      o_pc         <= '0;
      o_nxt_pc     <= '0;
      o_rs1_raddr  <= '0;
      o_rs2_raddr  <= '0;
      o_rs1_rdata  <= '0;
      o_rs2_rdata  <= '0;
      o_opsel      <= '0;
      o_dmem_addr  <= '0;
      o_dmem_wdata <= '0;
      o_dmem_ren   <= 1'b0;
      o_dmem_wen   <= 1'b0;
      o_mem_reg    <= 1'b0;
      o_res        <= '0;
      o_rd_waddr   <= '0;
      o_rd_wen     <= 1'b0;
    end else if (!i_stall) begin
      o_vld        <= i_vld;
      o_inst       <= i_inst;
      o_pc         <= i_pc;
      o_nxt_pc     <= nxt_pc;
      o_rs1_raddr  <= i_rs1_raddr;
      o_rs2_raddr  <= i_rs2_raddr;
      o_rs1_rdata  <= i_rs1_rdata;
      o_rs2_rdata  <= i_rs2_rdata;
      o_opsel      <= i_opsel;
      o_dmem_addr  <= alu_res;
      o_dmem_wdata <= i_rs2_rdata;
      o_dmem_ren   <= i_vld & i_dmem_ren;
      o_dmem_wen   <= i_vld & i_dmem_wen;
      o_mem_reg    <= i_mem_reg;
      o_res        <= res;
      o_rd_waddr   <= i_rd_waddr;
      o_rd_wen     <= i_vld & i_rd_wen;
    end
  end

endmodule

// File: tb/tb_execute.sv
// Bench for the execute stage: directed cases plus randomized traffic compared
// against an arithmetic reference model of the stage.
module tb_execute;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_flush, i_vld;
  logic [31:0] i_inst, i_pc, i_rs1_rdata, i_rs2_rdata, i_imm;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr, i_rd_waddr;
  logic [3:0]  i_alu_op;
  logic        i_alu_src;
  logic [2:0]  i_opsel;
  logic        i_branch, i_jal, i_jalr, i_dmem_ren, i_dmem_wen, i_mem_reg, i_rd_wen;

  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_vld;
  logic [31:0] o_inst, o_pc, o_nxt_pc, o_rs1_rdata, o_rs2_rdata;
  logic [4:0]  o_rs1_raddr, o_rs2_raddr, o_rd_waddr;
  logic [2:0]  o_opsel;
  logic [31:0] o_dmem_addr, o_dmem_wdata, o_res;
  logic        o_dmem_ren, o_dmem_wen, o_mem_reg, o_rd_wen;

  execute dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_vld(i_vld), .i_inst(i_inst), .i_pc(i_pc),
    .i_rs1_raddr(i_rs1_raddr), .i_rs2_raddr(i_rs2_raddr),
    .i_rs1_rdata(i_rs1_rdata), .i_rs2_rdata(i_rs2_rdata), .i_imm(i_imm),
    .i_alu_op(i_alu_op), .i_alu_src(i_alu_src), .i_opsel(i_opsel),
    .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
    .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen), .i_mem_reg(i_mem_reg),
    .i_rd_wen(i_rd_wen), .i_rd_waddr(i_rd_waddr),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_vld(o_vld), .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr),
    .o_rs1_rdata(o_rs1_rdata), .o_rs2_rdata(o_rs2_rdata),
    .o_opsel(o_opsel), .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen), .o_mem_reg(o_mem_reg),
    .o_res(o_res), .o_rd_waddr(o_rd_waddr), .o_rd_wen(o_rd_wen)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld;
    logic [31:0] inst, pc, nxt_pc, rs1d, rs2d, addr, wdata, res;
    logic [4:0]  rs1a, rs2a, rd;
    logic [2:0]  opsel;
    logic        ren, wen, mreg, rd_wen;
  } exp_t;

  exp_t m;
  bit   armed = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic red_s;
  logic [31:0] red_pc_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU using wide integer arithmetic rather than bit operators
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned sh = ub % 32;
    longint          p  = longint'(longint'(1) << sh);
    longint          r;
    case (op)
      4'd0:  return 32'(ua + ub);
      4'd1:  return 32'(ua - ub);
      4'd2:  return 32'(ua * longint'(p));
      4'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      4'd5:  return a ^ b;
      4'd6:  return 32'(ua / longint'(p));
      4'd7: begin
        if (sa >= 0) r = sa / p;
        else         r = -((-sa + p - 1) / p);
        return 32'(r);
      end
      4'd8:  return a | b;
      4'd9:  return a & b;
      4'd10: return b;
      4'd11: return 32'({32'd0, i_pc} + {32'd0, i_imm});
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken();
    longint sa = longint'($signed(i_rs1_rdata));
    longint sb = longint'($signed(i_rs2_rdata));
    longint unsigned ua = {32'd0, i_rs1_rdata};
    longint unsigned ub = {32'd0, i_rs2_rdata};
    logic c;
    case (i_opsel)
      3'd0: c = (ua == ub);
      3'd1: c = (ua != ub);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (ua < ub);
      3'd7: c = (ua >= ub);
      default: c = 1'b0;
    endcase
    return i_jal || i_jalr || (i_branch && c);
  endfunction

  function automatic logic [31:0] ref_target();
    if (i_jalr) return 32'(({32'd0, i_rs1_rdata} + {32'd0, i_imm}) / 2 * 2);
    return 32'({32'd0, i_pc} + {32'd0, i_imm});
  endfunction

  function automatic exp_t ref_load();
    exp_t e;
    logic [31:0] alu = ref_alu(i_alu_op, i_rs1_rdata, i_alu_src ? i_imm : i_rs2_rdata);
    logic [31:0] p4  = i_pc + 32'd4;
    e.vld    = i_vld;
    e.inst   = i_inst;
    e.pc     = i_pc;
    e.nxt_pc = ref_taken() ? ref_target() : p4;
    e.rs1a   = i_rs1_raddr;
    e.rs2a   = i_rs2_raddr;
    e.rs1d   = i_rs1_rdata;
    e.rs2d   = i_rs2_rdata;
    e.opsel  = i_opsel;
    e.addr   = alu;
    e.wdata  = i_rs2_rdata;
    e.ren    = i_vld && i_dmem_ren;
    e.wen    = i_vld && i_dmem_wen;
    e.mreg   = i_mem_reg;
    e.res    = (i_jal || i_jalr) ? p4 : alu;
    e.rd     = i_rd_waddr;
    e.rd_wen = i_vld && i_rd_wen;
    return e;
  endfunction

  function automatic exp_t zero_state();
    exp_t e;
    e = '{vld: 1'b0, inst: '0, pc: '0, nxt_pc: '0, rs1d: '0, rs2d: '0, addr: '0,
          wdata: '0, res: '0, rs1a: '0, rs2a: '0, rd: '0, opsel: '0,
          ren: 1'b0, wen: 1'b0, mreg: 1'b0, rd_wen: 1'b0};
    return e;
  endfunction

  task automatic check_regs();
    check("vld", o_vld, m.vld);          check("inst", o_inst, m.inst);
    check("pc", o_pc, m.pc);             check("nxt_pc", o_nxt_pc, m.nxt_pc);
    check("rs1a", o_rs1_raddr, m.rs1a);  check("rs2a", o_rs2_raddr, m.rs2a);
    check("rs1d", o_rs1_rdata, m.rs1d);  check("rs2d", o_rs2_rdata, m.rs2d);
    check("opsel", o_opsel, m.opsel);    check("addr", o_dmem_addr, m.addr);
    check("wdata", o_dmem_wdata, m.wdata);
    check("ren", o_dmem_ren, m.ren);     check("wen", o_dmem_wen, m.wen);
    check("mreg", o_mem_reg, m.mreg);    check("res", o_res, m.res);
    check("rd", o_rd_waddr, m.rd);       check("rd_wen", o_rd_wen, m.rd_wen);
  endtask

  // One clock: check redirect before the edge, advance model, check registers after
  task automatic cycle();
    #1;
    red_s    = o_redirect;
    red_pc_s = o_redirect_pc;
    check("redirect", o_redirect, i_vld && ref_taken() && !i_stall && !i_rst);
    check("redirect_pc", o_redirect_pc, ref_target());
    @(posedge i_clk);
    if (i_rst) begin
      m = zero_state();
      armed = 1'b1;
    end else if (i_flush) m = zero_state();
    else if (!i_stall) m = ref_load();
    #1;
    if (armed) check_regs();
  endtask

  task automatic clear_in();
    i_rst = 0; i_stall = 0; i_flush = 0; i_vld = 1;
    i_inst = 32'h0000_0013; i_pc = 32'h0; i_rs1_raddr = 5'd1; i_rs2_raddr = 5'd2;
    i_rs1_rdata = 0; i_rs2_rdata = 0; i_imm = 0; i_alu_op = 0; i_alu_src = 0;
    i_opsel = 0; i_branch = 0; i_jal = 0; i_jalr = 0; i_dmem_ren = 0;
    i_dmem_wen = 0; i_mem_reg = 0; i_rd_wen = 0; i_rd_waddr = 5'd3;
  endtask

  task automatic drive_rand();
    int cls = $urandom_range(0, 3);
    i_rst   = ($urandom_range(0, 99) < 3);
    i_stall = ($urandom_range(0, 99) < 25);
    i_flush = ($urandom_range(0, 99) < 10);
    i_vld   = ($urandom_range(0, 99) < 80);
    i_inst = $urandom; i_pc = $urandom & 32'hFFFF_FFFC;
    i_rs1_raddr = 5'($urandom); i_rs2_raddr = 5'($urandom); i_rd_waddr = 5'($urandom);
    i_rs1_rdata = ($urandom_range(0, 3) == 0) ? i_rs2_rdata : $urandom;
    i_rs2_rdata = $urandom; i_imm = $urandom;
    i_alu_op = 4'($urandom); i_alu_src = 1'($urandom); i_opsel = 3'($urandom);
    i_branch = (cls == 1); i_jal = (cls == 2); i_jalr = (cls == 3);
    i_dmem_ren = 1'($urandom); i_dmem_wen = 1'($urandom);
    i_mem_reg = 1'($urandom); i_rd_wen = 1'($urandom);
  endtask

  logic [31:0] held_res;

  initial begin
    clear_in();
    i_rst = 1; i_vld = 0;
    @(posedge i_clk); #1;
    cycle(); cycle();
    check("rst_vld", o_vld, 0);
    check("rst_wen", o_dmem_wen, 0);

    clear_in(); i_rs1_rdata = 32'h7FFF_FFFF; i_rs2_rdata = 1; i_rd_wen = 1;
    cycle(); check("add", o_res, 32'h8000_0000);
    clear_in(); i_rs1_rdata = 0; i_rs2_rdata = 1; i_alu_op = 1;
    cycle(); check("sub", o_res, 32'hFFFF_FFFF);
    clear_in(); i_rs1_rdata = 32'h8000_0000; i_imm = 4; i_alu_src = 1; i_alu_op = 7;
    cycle(); check("sra", o_res, 32'hF800_0000);
    i_alu_op = 6;
    cycle(); check("srl", o_res, 32'h0800_0000);
    clear_in(); i_rs1_rdata = 32'hFFFF_FFFF; i_rs2_rdata = 1; i_alu_op = 3;
    cycle(); check("slt", o_res, 1);
    i_alu_op = 4;
    cycle(); check("sltu", o_res, 0);

    clear_in(); i_pc = 32'h100; i_imm = 32'h20; i_rs1_rdata = 32'hFFFF_FFFE;
    i_rs2_rdata = 3; i_branch = 1; i_opsel = 3'b100;
    cycle();
    check("blt_red", red_s, 1); check("blt_redpc", red_pc_s, 32'h120);
    check("blt_nxt", o_nxt_pc, 32'h120);
    i_rs1_rdata = 2; i_opsel = 3'b111;
    cycle();
    check("bgeu_red", red_s, 0); check("bgeu_nxt", o_nxt_pc, 32'h104);

    clear_in(); i_pc = 32'h40; i_rs1_rdata = 32'h1003; i_jalr = 1; i_rd_wen = 1;
    cycle();
    check("jalr_redpc", red_pc_s, 32'h1002); check("jalr_res", o_res, 32'h44);
    check("jalr_rdwen", o_rd_wen, 1);

    clear_in(); i_rs1_rdata = 32'h2000; i_imm = 8; i_alu_src = 1;
    i_rs2_rdata = 32'hDEAD_BEEF; i_dmem_wen = 1; i_opsel = 3'b010;
    cycle();
    check("sw_addr", o_dmem_addr, 32'h2008); check("sw_wdata", o_dmem_wdata, 32'hDEAD_BEEF);
    check("sw_wen", o_dmem_wen, 1); check("sw_opsel", o_opsel, 3'b010);

    // Stall three cycles with a pending jump, then release
    clear_in(); i_rs1_rdata = 32'h10; i_rs2_rdata = 32'h20; i_rd_wen = 1;
    cycle(); held_res = o_res;
    check("stall_pre", held_res, 32'h30);
    i_stall = 1; i_jal = 1; i_pc = 32'h200; i_imm = 32'h80; i_rs1_rdata = 32'h55;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_hold", o_res, 32'h30);
      check("stall_nored", red_s, 0);
    end
    i_stall = 0;
    cycle();
    check("stall_fire", red_s, 1); check("stall_res", o_res, 32'h204);

    clear_in(); i_rd_wen = 1; i_stall = 1; i_flush = 1;
    cycle();
    check("sf_vld", o_vld, 0); check("sf_rdwen", o_rd_wen, 0);

    clear_in(); i_rd_wen = 1; i_rs1_rdata = 5;
    cycle();
    i_stall = 1; i_rst = 1;
    cycle();
    check("rst_stall_vld", o_vld, 0); check("rst_stall_res", o_res, 0);

    clear_in(); i_vld = 0; i_rd_wen = 1; i_dmem_ren = 1; i_dmem_wen = 1; i_jal = 1;
    cycle();
    check("inv_vld", o_vld, 0); check("inv_wen", o_dmem_wen, 0);
    check("inv_ren", o_dmem_ren, 0); check("inv_red", red_s, 0);

    for (int k = 0; k < 600; k++) begin
      drive_rand();
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
